mul_array: RTL and testbench

MUL_ARRAY -- requirements
Module: mul_array

---
 rtl/mul_array.sv | 207 ++++++++++++++++++++
 tb/tb_mul_array.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_array.sv
// Multi-lane multiplier array: input FIFO, iteration/read sequencer and a 2-stage product pipeline.
// Optional MUL_ARRAY_SAT_EN: per-lane rounded right-shift with saturation to DATA_WIDTH.
module mul_array #(
    parameter int NUM_LANES              = 4,
    parameter int DATA_WIDTH             = 8,
    parameter int REP_INFO_WIDTH         = 16,
    parameter int FIFO_DEPTH             = 4,
    parameter int LOG_MAX_ITERS          = 16,
    parameter int LOG_MAX_READS_PER_ITER = 16,
    localparam int IN_WIDTH    = NUM_LANES * 2 * DATA_WIDTH + REP_INFO_WIDTH,
    localparam int OUT_WIDTH   = IN_WIDTH,
    localparam int SHIFT_WIDTH = $clog2(2 * DATA_WIDTH)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              configure,
    input  logic [LOG_MAX_ITERS-1:0]          num_iters,
    input  logic [LOG_MAX_READS_PER_ITER-1:0] num_reads_per_iter,
    input  logic                              signed_mode,
    input  logic [SHIFT_WIDTH-1:0]            shift,
    input  logic [IN_WIDTH-1:0]               data_in,
    input  logic                              valid_in,
    output logic                              avail_out,
    output logic [OUT_WIDTH-1:0]              data_out,
    output logic                              valid_out,
    input  logic                              avail_in,
    output logic                              busy,
    output logic                              done
);
    localparam int PW        = 2 * DATA_WIDTH;
    localparam int LANE_BITS = NUM_LANES * PW;
    localparam int PTR_W     = $clog2(FIFO_DEPTH);

    logic [IN_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_reg, rd_ptr_reg;
    logic [PTR_W:0]      count_reg;
    logic                full, almost_full, empty, wr_en, fire;
    logic [IN_WIDTH-1:0] head;

    logic [LOG_MAX_ITERS-1:0]          iters_cnt_reg;
    logic [LOG_MAX_READS_PER_ITER-1:0] reads_cnt_reg, reads_cfg_reg;
    logic                              signed_mode_reg, busy_reg, done_reg;

    logic [LANE_BITS-1:0]      product, prod_reg, result;
    logic [REP_INFO_WIDTH-1:0] rep_reg;
    logic                      valid1_reg;

    assign full        = (count_reg == (PTR_W + 1)'(FIFO_DEPTH));
    assign almost_full = (count_reg == (PTR_W + 1)'(FIFO_DEPTH - 1));
    assign empty       = (count_reg == '0);
    assign avail_out   = ~full & ~almost_full;
    assign wr_en       = valid_in & ~full;
    assign fire        = busy_reg & ~empty & avail_in & ~configure;
    assign head        = fifo_mem[rd_ptr_reg];
    assign busy        = busy_reg;
    assign done        = done_reg;

    // Storage is not reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (wr_en)
            fifo_mem[wr_ptr_reg] <= data_in;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (wr_en)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (fire)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({wr_en, fire})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Sequencer: configure restarts counts; a zero count finishes immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            iters_cnt_reg   <= '0;
            reads_cnt_reg   <= '0;
            reads_cfg_reg   <= '0;
            signed_mode_reg <= 1'b0;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (configure) begin
                iters_cnt_reg   <= num_iters;
                reads_cnt_reg   <= num_reads_per_iter;
                reads_cfg_reg   <= num_reads_per_iter;
                signed_mode_reg <= signed_mode;
                if (num_iters != '0 && num_reads_per_iter != '0) begin
                    busy_reg <= 1'b1;
                end else begin
                    busy_reg <= 1'b0;
                    done_reg <= 1'b1;
                end
            end else if (fire) begin
                if (reads_cnt_reg == LOG_MAX_READS_PER_ITER'(1)) begin
                    reads_cnt_reg <= reads_cfg_reg;
                    if (iters_cnt_reg == LOG_MAX_ITERS'(1)) begin
                        busy_reg <= 1'b0;
                        done_reg <= 1'b1;
                    end else begin
                        iters_cnt_reg <= iters_cnt_reg - 1'b1;
                    end
                end else begin
                    reads_cnt_reg <= reads_cnt_reg - 1'b1;
                end
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_mul
            logic [DATA_WIDTH-1:0] act, wgt;
            logic [PW-1:0]         act_ext, wgt_ext;
            assign act     = head[gi*PW +: DATA_WIDTH];
            assign wgt     = head[gi*PW+DATA_WIDTH +: DATA_WIDTH];
            // Extending both operands to PW bits makes the truncated product exact in either mode.
            assign act_ext = {{DATA_WIDTH{signed_mode_reg & act[DATA_WIDTH-1]}}, act};
            assign wgt_ext = {{DATA_WIDTH{signed_mode_reg & wgt[DATA_WIDTH-1]}}, wgt};
            assign product[gi*PW +: PW] = act_ext * wgt_ext;
        end
    endgenerate

`ifdef MUL_ARRAY_SAT_EN
    logic                   s1_signed_reg;
    logic [SHIFT_WIDTH-1:0] shift_reg, s1_shift_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_reg     <= '0;
            s1_shift_reg  <= '0;
            s1_signed_reg <= 1'b0;
        end else begin
            if (configure)
                shift_reg <= shift;
            if (fire) begin
                s1_shift_reg  <= shift_reg;
                s1_signed_reg <= signed_mode_reg;
            end
        end
    end

    localparam logic signed [PW:0] SMAX = (PW + 1)'(2 ** (DATA_WIDTH - 1) - 1);
    localparam logic signed [PW:0] SMIN = (PW + 1)'(-(2 ** (DATA_WIDTH - 1)));
    localparam logic signed [PW:0] UMAX = (PW + 1)'(2 ** DATA_WIDTH - 1);

    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_sat
            logic signed [PW:0]    wide, shifted, rounded;
            logic [PW:0]           half_mask;
            logic                  round_bit;
            logic [DATA_WIDTH-1:0] sat;
            assign wide      = {s1_signed_reg & prod_reg[gi*PW+PW-1], prod_reg[gi*PW +: PW]};
            assign shifted   = wide >>> s1_shift_reg;
            assign half_mask = ((PW + 1)'(1) << s1_shift_reg) >> 1;
            assign round_bit = |(wide & half_mask);
            assign rounded   = shifted + $signed({{PW{1'b0}}, round_bit});
            always_comb begin
                sat = rounded[DATA_WIDTH-1:0];
                if (s1_signed_reg) begin
                    if (rounded > SMAX)
                        sat = SMAX[DATA_WIDTH-1:0];
                    else if (rounded < SMIN)
                        sat = SMIN[DATA_WIDTH-1:0];
                end else if (rounded > UMAX) begin
                    sat = UMAX[DATA_WIDTH-1:0];
                end
            end
            assign result[gi*PW +: PW] = {{DATA_WIDTH{s1_signed_reg & sat[DATA_WIDTH-1]}}, sat};
        end
    endgenerate
`else
    logic unused_shift;
    assign unused_shift = ^shift;
    assign result       = prod_reg;
`endif

    // Two-stage pipeline with no stall: anything fired always reaches the output.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prod_reg   <= '0;
            rep_reg    <= '0;
            valid1_reg <= 1'b0;
            data_out   <= '0;
            valid_out  <= 1'b0;
        end else begin
            valid1_reg <= fire;
            if (fire) begin
                prod_reg <= product;
                rep_reg  <= head[IN_WIDTH-1 -: REP_INFO_WIDTH];
            end
            valid_out <= valid1_reg;
            if (valid1_reg)
                data_out <= {rep_reg, result};
        end
    end
endmodule

// File: tb/tb_mul_array.sv
// Directed self-checking bench for mul_array (default parameters); sat expectations under MUL_ARRAY_SAT_EN.
module tb_mul_array;
    localparam int NL = 4, DW = 8, RW = 16, LI = 16, LR = 16;
    localparam int IW = NL * 2 * DW + RW;
    localparam int SW = $clog2(2 * DW);
`ifdef MUL_ARRAY_SAT_EN
    localparam logic [15:0] FF_SQ = 16'h00FF;
`else
    localparam logic [15:0] FF_SQ = 16'hFE01;
`endif

    logic          clk = 1'b0, rst = 1'b0, configure = 1'b0, signed_mode = 1'b0;
    logic          valid_in = 1'b0, avail_in = 1'b1;
    logic [LI-1:0] num_iters = '0;
    logic [LR-1:0] num_reads_per_iter = '0;
    logic [SW-1:0] shift = '0;
    logic [IW-1:0] data_in = '0;
    logic [IW-1:0] data_out;
    logic          valid_out, avail_out, busy, done;

    mul_array dut (
        .clk(clk), .rst(rst), .configure(configure), .num_iters(num_iters),
        .num_reads_per_iter(num_reads_per_iter), .signed_mode(signed_mode), .shift(shift),
        .data_in(data_in), .valid_in(valid_in), .avail_out(avail_out),
        .data_out(data_out), .valid_out(valid_out), .avail_in(avail_in),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0, cyc = 0, done_cnt = 0, last_done_cyc = -1;
    logic [IW-1:0] outq[$];
    int out_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid_out) begin
            outq.push_back(data_out);
            out_cyc.push_back(cyc);
            $display("OUT cyc=%0d data=%h", cyc, data_out);
        end
        if (done) begin
            done_cnt++;
            last_done_cyc = cyc;
        end
    end

    typedef struct {
        logic          sm;
        logic [SW-1:0] sh;
        logic [31:0]   a;
        logic [31:0]   w;
        logic [63:0]   e;
    } vec_t;
    vec_t tbl[4];
    int   ntbl;

    task automatic chk(string name, logic [IW-1:0] act, logic [IW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic tick(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [IW-1:0] word(logic [31:0] a, logic [31:0] w, logic [15:0] rep);
        logic [IW-1:0] d;
        d = '0;
        for (int i = 0; i < NL; i++) begin
            d[16*i +: 8]   = a[8*i +: 8];
            d[16*i+8 +: 8] = w[8*i +: 8];
        end
        d[IW-1 -: 16] = rep;
        return d;
    endfunction

    task automatic push(logic [31:0] a, logic [31:0] w, logic [15:0] rep);
        data_in  = word(a, w, rep);
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
    endtask

    task automatic cfg(int iters, int reads, logic sm, logic [SW-1:0] sh);
        num_iters          = LI'(iters);
        num_reads_per_iter = LR'(reads);
        signed_mode        = sm;
        shift              = sh;
        configure          = 1'b1;
        tick();
        configure          = 1'b0;
    endtask

    task automatic wait_out(int n, int budget);
        int t = 0;
        while (outq.size() < n && t < budget) begin
            tick();
            t++;
        end
    endtask

    initial begin
        int d0;
`ifdef MUL_ARRAY_SAT_EN
        tbl[0] = '{1'b0, SW'(4), {8'h00, 8'h10, 8'h02, 8'hFF}, {8'hAB, 8'h10, 8'h03, 8'hFF},
                   {16'h0000, 16'h0010, 16'h0000, 16'h00FF}};
        tbl[1] = '{1'b1, SW'(4), {8'h01, 8'h7F, 8'hFE, 8'h80}, {8'h08, 8'h81, 8'h03, 8'h80},
                   {16'h0001, 16'hFF80, 16'h0000, 16'h007F}};
        ntbl = 2;
`else
        tbl[0] = '{1'b0, SW'(0), {8'h00, 8'h10, 8'h02, 8'hFF}, {8'hAB, 8'h10, 8'h03, 8'hFF},
                   {16'h0000, 16'h0100, 16'h0006, 16'hFE01}};
        tbl[1] = '{1'b1, SW'(0), {8'h80, 8'hFF, 8'h7F, 8'h80}, {8'h80, 8'hFF, 8'h81, 8'hFF},
                   {16'h4000, 16'h0001, 16'hC0FF, 16'h0080}};
        tbl[2] = '{1'b0, SW'(0), {8'hFF, 8'h12, 8'h7F, 8'h80}, {8'h01, 8'h34, 8'h81, 8'hFF},
                   {16'h00FF, 16'h03A8, 16'h3FFF, 16'h7F80}};
        tbl[3] = '{1'b1, SW'(0), {8'h00, 8'h7F, 8'h05, 8'hFE}, {8'h80, 8'h7F, 8'hFB, 8'h03},
                   {16'h0000, 16'h3F01, 16'hFFE7, 16'hFFFA}};
        ntbl = 4;
`endif
        // Reset state
        tick(3);
        chk("rst_valid_out", IW'(valid_out), IW'(0));
        chk("rst_busy", IW'(busy), IW'(0));
        chk("rst_done", IW'(done), IW'(0));
        chk("rst_data_out", data_out, '0);
        chk("rst_avail_out", IW'(avail_out), IW'(1));
        rst = 1'b1;
        tick();

        // Table: one word per vector, exact 2-cycle latency and done timing
        for (int v = 0; v < ntbl; v++) begin
            outq.delete();
            push(tbl[v].a, tbl[v].w, 16'(16'hA0 + v));
            cfg(1, 1, tbl[v].sm, tbl[v].sh);
            chk($sformatf("v%0d_busy_set", v), IW'(busy), IW'(1));
            tick();
            chk($sformatf("v%0d_n1_valid", v), IW'(valid_out), IW'(0));
            chk($sformatf("v%0d_n1_done", v), IW'(done), IW'(1));
            chk($sformatf("v%0d_n1_busy", v), IW'(busy), IW'(0));
            tick();
            chk($sformatf("v%0d_n2_valid", v), IW'(valid_out), IW'(1));
            chk($sformatf("v%0d_n2_data", v), data_out, {16'(16'hA0 + v), tbl[v].e});
            chk($sformatf("v%0d_n2_done", v), IW'(done), IW'(0));
            tick();
            chk($sformatf("v%0d_n3_valid", v), IW'(valid_out), IW'(0));
        end

        // Two iterations of three reads, unsigned 0xFF*0xFF
        outq.delete(); out_cyc.delete();
        d0 = done_cnt;
        cfg(2, 3, 1'b0, SW'(0));
        for (int k = 0; k < 6; k++) push(32'hFFFF_FFFF, 32'hFFFF_FFFF, 16'(k));
        wait_out(6, 50);
        tick(4);
        chk("seq_count", IW'(outq.size()), IW'(6));
        for (int k = 0; k < 6 && k < outq.size(); k++)
            chk($sformatf("seq_word%0d", k), outq[k], {16'(k), {4{FF_SQ}}});
        chk("seq_done_cnt", IW'(done_cnt - d0), IW'(1));
        if (out_cyc.size() == 6)
            chk("seq_done_timing", IW'(last_done_cyc), IW'(out_cyc[5] - 1));
        chk("seq_busy_end", IW'(busy), IW'(0));

        // Backpressure, almost-full, full and write drop
        outq.delete();
        d0 = done_cnt;
        avail_in = 1'b0;
        cfg(1, 4, 1'b0, SW'(0));
        for (int k = 0; k < 5; k++) begin
            push({4{8'(k + 1)}}, {4{8'h03}}, 16'(16'h10 + k));
            if (k == 1) chk("bp_avail_2w", IW'(avail_out), IW'(1));
            if (k == 2) chk("bp_avail_3w", IW'(avail_out), IW'(0));
        end
        tick(5);
        chk("bp_no_output", IW'(outq.size()), IW'(0));
        avail_in = 1'b1;
        wait_out(4, 30);
        tick(4);
        chk("bp_count", IW'(outq.size()), IW'(4));
        for (int k = 0; k < 4 && k < outq.size(); k++)
            chk($sformatf("bp_word%0d", k), outq[k], {16'(16'h10 + k), {4{16'(3 * (k + 1))}}});
        chk("bp_done_cnt", IW'(done_cnt - d0), IW'(1));
        cfg(1, 1, 1'b0, SW'(0));
        tick(6);
        chk("bp_dropped", IW'(outq.size()), IW'(4));
        chk("bp_idle_busy", IW'(busy), IW'(1));

        // Zero counts finish immediately (also aborts the pending sequence)
        d0 = done_cnt;
        cfg(5, 0, 1'b0, SW'(0));
        chk("zero_reads_busy", IW'(busy), IW'(0));
        chk("zero_reads_done", IW'(done), IW'(1));
        tick();
        chk("zero_reads_done_off", IW'(done), IW'(0));
        cfg(0, 2, 1'b0, SW'(0));
        chk("zero_iters_done", IW'(done), IW'(1));
        tick();
        chk("zero_done_cnt", IW'(done_cnt - d0), IW'(2));

        // Reconfigure with two results in flight
        outq.delete();
        for (int k = 0; k < 3; k++) push(32'hFFFF_FFFF, 32'hFFFF_FFFF, 16'(16'h20 + k));
        d0 = done_cnt;
        cfg(1, 4, 1'b0, SW'(0));
        tick(2);
        cfg(1, 1, 1'b1, SW'(0));
        wait_out(3, 20);
        tick(4);
        chk("reconf_count", IW'(outq.size()), IW'(3));
        if (outq.size() == 3) begin
            chk("reconf_word0", outq[0], {16'h20, {4{FF_SQ}}});
            chk("reconf_word1", outq[1], {16'h21, {4{FF_SQ}}});
            chk("reconf_word2", outq[2], {16'h22, {4{16'h0001}}});
        end
        chk("reconf_done_cnt", IW'(done_cnt - d0), IW'(1));
        chk("reconf_busy", IW'(busy), IW'(0));

        // Asynchronous reset with a full FIFO and two results in flight
        outq.delete();
        for (int k = 0; k < 4; k++) push(32'h0101_0101, 32'h0202_0202, 16'(16'h30 + k));
        chk("mid_full_avail", IW'(avail_out), IW'(0));
        cfg(1, 8, 1'b0, SW'(0));
        tick(2);
        rst = 1'b0;
        #1;
        chk("mid_rst_valid", IW'(valid_out), IW'(0));
        chk("mid_rst_data", data_out, '0);
        chk("mid_rst_busy", IW'(busy), IW'(0));
        chk("mid_rst_avail", IW'(avail_out), IW'(1));
        tick(2);
        #2;
        rst = 1'b1;
        d0 = done_cnt;
        cfg(1, 0, 1'b0, SW'(0));
        chk("post_rst_cfg_done", IW'(done), IW'(1));
        cfg(1, 1, 1'b0, SW'(0));
        tick(8);
        chk("post_rst_no_output", IW'(outq.size()), IW'(0));
        chk("post_rst_done_cnt", IW'(done_cnt - d0), IW'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
